vram_write_arbiter: RTL and testbench
=====================================

# vram_write_arbiter

Write-port arbiter and hardware fill engine for the character VRAM (E800h–EFFFh) and attribute VRAM (E000h–E7FFh) of the Micro-80 video controller. It owns the single write port of both 2 KiB dual-port RAMs and shares it between two requesters:
- asynchronous CPU bus writes, resynchronised into the pixel clock domain;
- a fill/clear engine that writes a character code and attribute into a range of cells.

The read ports stay with the character scan-out logic and are not touched.

## Interface
Parameters:
- SYNC_STAGES, 2 — number of wr_n synchroniser flops; the edge-detect flop comes after these.
- VRAM_AW, 11 — VRAM address width (2048 cells).

Ports:
- clk  in  1  pixel clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_n  in  1  CPU write strobe, active-low, asynchronous to clk.
- mreq_n  in  1  CPU memory request, active-low.
- add  in  16  CPU address.
- din  in  8  CPU data.
- fill_start  in  1  one-clk pulse that starts a fill.
- fill_base  in  11  first cell index of the fill.
- fill_len  in  12  number of cells to fill; 0 means no-op, values >2048 are clamped to 2048.
- fill_char  in  8  character code written to char VRAM.
- fill_attr  in  8  attribute written to attribute VRAM.
- vr_we  out  1  char VRAM write enable, one clk wide.
- ar_we  out  1  attribute VRAM write enable, one clk wide.
- wadd  out  11  write address.
- wdata  out  8  write data.
- busy  out  1  fill engine active.
- done  out  1  one-clk pulse when a fill completes.

## Operation
- CPU path:
  - wr_n passes through SYNC_STAGES flops, then one edge-detect flop.
  - A CPU event is a falling edge on the synchronised wr_n while mreq_n = 0, sampled in the same cycle the edge is detected.
  - Decode on the event: add in E800h–EFFFh → char write; add in E000h–E7FFh → attribute write; any other address → ignored, no strobe.
  - wadd = add[10:0], wdata = din.
- Fill FSM states: IDLE, CHAR, ATTR, FIN.
  - IDLE: fill_start with clamped fill_len ≠ 0 → latch base/len/char/attr, clear idx, go to CHAR, busy = 1. fill_start with len = 0 → done pulse, stay in IDLE, busy stays 0.
  - CHAR: issue vr_we at (base+idx) mod 2048 with fill_char → ATTR.
  - ATTR: issue ar_we at the same address with fill_attr. idx+1 == len → FIN, else idx+1 and go to CHAR.
  - FIN: done = 1 for one clk, busy = 0 → IDLE.
  - idx is a 12-bit counter. The address sum is 11-bit and wraps modulo 2048 (base 7FFh, idx 1 → 000h).
- Arbitration, fixed priority CPU > fill:
  - In a cycle with a CPU event, the CPU write is issued. The fill engine holds its state, idx and pending beat, and resumes the next cycle with no lost or duplicated writes.
  - An ignored CPU event (out-of-range address) does not stall the fill.
- fill_start while busy = 1 is ignored; latched parameters do not change.
- vr_we and ar_we are never high in the same cycle.
- Reset mid-fill: FSM returns to IDLE and the partial fill is abandoned. busy = 0, no done pulse.

## Timing
- Reset values:
  - Outputs: vr_we = 0, ar_we = 0, wadd = 000h, wdata = 00h, busy = 0, done = 0.
  - Synchroniser and edge-detect flops reset to 1 (bus idle).
- All outputs are registered.
- CPU latency, with SYNC_STAGES = 2:
  - wr_n first sampled low at edge k → event decoded after edge k+1 → strobe, wadd and wdata registered at edge k+2, high for exactly one clk.
  - add, din and mreq_n must be stable from edge k through edge k+2.
- Fill latency and throughput:
  - fill_start sampled at edge n → busy = 1 from edge n+1 → first vr_we at edge n+2.
  - Unstalled, each cell takes 2 clks.
  - For len L with S CPU-stolen cycles: last ar_we at edge n+1+2L+S, done at the following edge, busy low together with done.
- One CPU write per wr_n low pulse; wr_n must stay high at least SYNC_STAGES+1 clks between writes.

## Test plan
- Reset: hold rst = 0 with wr_n toggling → all outputs 0. Release rst, no activity → no strobes.
- CPU decode:
  - wr_n low 6 clks, mreq_n = 0, add = E805h, din = 41h → single vr_we at edge k+2, wadd = 005h, wdata = 41h.
  - Repeat with add = E123h, din = 1Fh → single ar_we, wadd = 123h, wdata = 1Fh.
  - add = F000h, and separately mreq_n = 1 → no strobe.
- Fill: base = 010h, len = 3, char 20h, attr 07h → alternating vr_we/ar_we at 010h, 010h, 011h, 011h, 012h, 012h on consecutive clks; done one clk after the last ar_we; busy high 7 clks.
- Wrap and clamp:
  - base = 7FEh, len = 3 → addresses 7FEh, 7FFh, 000h.
  - len = FFFh → exactly 2048 cells, 4096 strobes.
  - len = 0 → done pulse only, no strobes.
- Collision: CPU event lands in the cycle of the fill's 2nd vr_we → CPU write issued that cycle, fill beat delayed one clk, total strobes = 2L+1, done delayed by one clk.
- Restart and abort:
  - fill_start while busy → ignored.
  - rst low mid-fill → no further strobes, no done pulse.
  - A new fill after reset runs normally.

Source files
------------

// File: rtl/vram_write_arbiter_if.sv
// Bus bundle between the VRAM write arbiter and its requesters: CPU write bus,
// fill request and the shared VRAM write port.
interface vram_write_arbiter_if #(
    parameter int VRAM_AW = 11
);
    logic               wr_n;
    logic               mreq_n;
    logic [15:0]        add;
    logic [7:0]         din;
    logic               fill_start;
    logic [VRAM_AW-1:0] fill_base;
    logic [VRAM_AW:0]   fill_len;
    logic [7:0]         fill_char;
    logic [7:0]         fill_attr;
    logic               vr_we;
    logic               ar_we;
    logic [VRAM_AW-1:0] wadd;
    logic [7:0]         wdata;
    logic               busy;
    logic               done;

    modport master (
        output wr_n, mreq_n, add, din,
        output fill_start, fill_base, fill_len, fill_char, fill_attr,
        input  vr_we, ar_we, wadd, wdata, busy, done
    );

    modport slave (
        input  wr_n, mreq_n, add, din,
        input  fill_start, fill_base, fill_len, fill_char, fill_attr,
        output vr_we, ar_we, wadd, wdata, busy, done
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Owns the write port of the character and attribute VRAMs: resynchronised CPU
// writes take fixed priority over a fill engine that writes one cell per two clks.
module vram_write_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int VRAM_AW     = 11
) (
    input  logic                clk,
    input  logic                rst,
    vram_write_arbiter_if.slave bus
);
    localparam int LW = VRAM_AW + 1;
    localparam logic [LW-1:0] ZERO_C  = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_C   = {{VRAM_AW{1'b0}}, 1'b1};
    localparam logic [LW-1:0] CELLS_C = {1'b1, {VRAM_AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAR = 2'd1,
        ST_ATTR = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;
    logic                   cpu_evt_s;
    logic                   cpu_char_s;
    logic                   cpu_attr_s;
    logic                   cpu_hit_s;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic                   start_r;
    logic                   start_nx_s;
    logic                   latch_s;
    logic [LW-1:0]          len_clamp_s;
    logic [VRAM_AW-1:0]     base_r;
    logic [LW-1:0]          len_r;
    logic [LW-1:0]          idx_r;
    logic [LW-1:0]          idx_nx_s;
    logic [7:0]             char_r;
    logic [7:0]             attr_r;
    logic [VRAM_AW-1:0]     fill_addr_s;
    logic                   fill_vr_s;
    logic                   fill_ar_s;
    logic                   done_nx_s;

    logic                   vr_we_r;
    logic                   ar_we_r;
    logic                   busy_r;
    logic                   done_r;
    logic [VRAM_AW-1:0]     wadd_r;
    logic [VRAM_AW-1:0]     wadd_nx_s;
    logic [7:0]             wdata_r;
    logic [7:0]             wdata_nx_s;

    // Resynchronise wr_n and keep one extra flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            edge_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.wr_n};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // CPU event decode; out-of-range addresses never claim the write port.
    always_comb begin
        cpu_evt_s   = edge_r & ~sync_r[SYNC_STAGES-1] & ~bus.mreq_n;
        cpu_char_s  = cpu_evt_s & (bus.add[15:11] == 5'b11101);
        cpu_attr_s  = cpu_evt_s & (bus.add[15:11] == 5'b11100);
        cpu_hit_s   = cpu_char_s | cpu_attr_s;
        len_clamp_s = (bus.fill_len > CELLS_C) ? CELLS_C : bus.fill_len;
        fill_addr_s = base_r + idx_r[VRAM_AW-1:0];
    end

    // Fill engine next state; a CPU hit freezes CHAR/ATTR so the pending beat is kept.
    always_comb begin
        state_nx_s = state_r;
        start_nx_s = start_r;
        idx_nx_s   = idx_r;
        latch_s    = 1'b0;
        fill_vr_s  = 1'b0;
        fill_ar_s  = 1'b0;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_r) begin
                    start_nx_s = 1'b0;
                    state_nx_s = ST_CHAR;
                end else if (bus.fill_start) begin
                    if (len_clamp_s != ZERO_C) begin
                        latch_s    = 1'b1;
                        start_nx_s = 1'b1;
                        idx_nx_s   = ZERO_C;
                    end else begin
                        done_nx_s  = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CHAR: begin
                if (cpu_hit_s) begin
                    state_nx_s = ST_CHAR;
                end else begin
                    fill_vr_s  = 1'b1;
                    state_nx_s = ST_ATTR;
                end
            end
            ST_ATTR: begin
                if (cpu_hit_s) begin
                    state_nx_s = ST_ATTR;
                end else begin
                    fill_ar_s = 1'b1;
                    if ((idx_r + ONE_C) == len_r) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        idx_nx_s   = idx_r + ONE_C;
                        state_nx_s = ST_CHAR;
                    end
                end
            end
            ST_FIN: begin
                done_nx_s  = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Write port mux: CPU first, then the fill beat, otherwise hold.
    always_comb begin
        wadd_nx_s  = wadd_r;
        wdata_nx_s = wdata_r;
        if (cpu_hit_s) begin
            wadd_nx_s  = bus.add[VRAM_AW-1:0];
            wdata_nx_s = bus.din;
        end else if (fill_vr_s) begin
            wadd_nx_s  = fill_addr_s;
            wdata_nx_s = char_r;
        end else if (fill_ar_s) begin
            wadd_nx_s  = fill_addr_s;
            wdata_nx_s = attr_r;
        end else begin
            wadd_nx_s  = wadd_r;
            wdata_nx_s = wdata_r;
        end
    end

    // Fill FSM state, counter and latched fill parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            start_r <= 1'b0;
            idx_r   <= ZERO_C;
            base_r  <= {VRAM_AW{1'b0}};
            len_r   <= ZERO_C;
            char_r  <= 8'h00;
            attr_r  <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            start_r <= start_nx_s;
            idx_r   <= idx_nx_s;
            if (latch_s) begin
                base_r <= bus.fill_base;
                len_r  <= len_clamp_s;
                char_r <= bus.fill_char;
                attr_r <= bus.fill_attr;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vr_we_r <= 1'b0;
            ar_we_r <= 1'b0;
            wadd_r  <= {VRAM_AW{1'b0}};
            wdata_r <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            vr_we_r <= cpu_char_s | fill_vr_s;
            ar_we_r <= cpu_attr_s | fill_ar_s;
            wadd_r  <= wadd_nx_s;
            wdata_r <= wdata_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= done_nx_s;
        end
    end

    assign bus.vr_we = vr_we_r;
    assign bus.ar_we = ar_we_r;
    assign bus.wadd  = wadd_r;
    assign bus.wdata = wdata_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: decode table, directed fill corner cases and
// randomised fills with CPU traffic checked against a slot-scheduling model.
module tb_vram_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vram_write_arbiter_if bus ();
    vram_write_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int cyc; bit vr; bit ar; logic [10:0] a; logic [7:0] d; } wr_t;
    typedef struct { int off; int low; logic [15:0] a; logic [7:0] d; bit mreq_n; } cpu_t;
    typedef struct { logic [15:0] a; logic [7:0] d; bit mreq_n; bit vr; bit ar; logic [10:0] wa; } vec_t;

    wr_t  act_q[$];
    int   done_q[$];
    cpu_t plan_q[$];
    int   busy_cnt = 0;
    int   both_cnt = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe, done pulse and busy cycle, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t r;
        if (bus.vr_we || bus.ar_we) begin
            r.cyc = cyc; r.vr = bus.vr_we; r.ar = bus.ar_we; r.a = bus.wadd; r.d = bus.wdata;
            act_q.push_back(r);
        end
        if (bus.done) done_q.push_back(cyc);
        if (bus.busy) busy_cnt++;
        if (bus.vr_we && bus.ar_we) both_cnt++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input wr_t r, input int n);
        return {11'd0, 32'(r.cyc - n), r.vr, r.ar, r.a, r.d};
    endfunction

    function automatic bit in_range(input logic [15:0] a);
        return (a >= 16'hE000) && (a <= 16'hEFFF);
    endfunction

    task automatic clear_mon();
        @(posedge clk);
        #1;
        act_q.delete(); done_q.delete(); busy_cnt = 0; both_cnt = 0;
    endtask

    // Drive one scenario (optional fill plus plan_q CPU pulses) and compare to the model.
    task automatic run(input bit do_fill, input logic [10:0] base, input logic [11:0] len,
                       input logic [7:0] ch, input logic [7:0] at, input bit restart);
        int  n, total, lc, last, bi, maxoff, exp_done;
        wr_t exp_q[$];
        int  cpu_at[int];
        wr_t r;
        clear_mon();
        @(negedge clk);
        n = cyc + 1;
        last_n = n;
        lc = (len > 12'd2048) ? 2048 : int'(len);
        maxoff = 0;
        foreach (plan_q[j]) if (plan_q[j].off + plan_q[j].low > maxoff) maxoff = plan_q[j].off + plan_q[j].low;
        total = do_fill ? (2 * lc + plan_q.size() + 8) : 0;
        if (maxoff + 8 > total) total = maxoff + 8;
        for (int i = 0; i < total; i++) begin
            bus.fill_start = (do_fill && i == 0) || (restart && i == 3);
            if (i == 0) begin
                bus.fill_base = base; bus.fill_len = len; bus.fill_char = ch; bus.fill_attr = at;
            end else if (i == 3) begin
                bus.fill_base = base ^ 11'h155; bus.fill_len = 12'd7;
                bus.fill_char = ~ch; bus.fill_attr = ~at;
            end
            foreach (plan_q[j]) begin
                if (i == plan_q[j].off) begin
                    bus.wr_n = 1'b0; bus.add = plan_q[j].a; bus.din = plan_q[j].d; bus.mreq_n = plan_q[j].mreq_n;
                end
                if (i == plan_q[j].off + plan_q[j].low) bus.wr_n = 1'b1;
            end
            @(negedge clk);
        end
        bus.fill_start = 1'b0;
        bus.mreq_n = 1'b1;
        // Model: CPU writes own cycle k+2; fill beats take every other free cycle from n+2.
        foreach (plan_q[j]) if (!plan_q[j].mreq_n && in_range(plan_q[j].a)) cpu_at[n + plan_q[j].off + 2] = j;
        bi = 0;
        last = n;
        for (int c = n; c <= n + total - 1; c++) begin
            if (cpu_at.exists(c)) begin
                r.cyc = c; r.vr = (plan_q[cpu_at[c]].a[11] == 1'b1); r.ar = !r.vr;
                r.a = plan_q[cpu_at[c]].a[10:0]; r.d = plan_q[cpu_at[c]].d;
                exp_q.push_back(r);
            end else if (bi < 2 * lc && c >= n + 2) begin
                r.cyc = c; r.vr = (bi % 2 == 0); r.ar = !r.vr;
                r.a = 11'((int'(base) + bi / 2) % 2048); r.d = r.vr ? ch : at;
                exp_q.push_back(r);
                last = c;
                bi++;
            end
        end
        exp_done = (lc == 0) ? n : last + 1;
        check("strobe_count", act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check($sformatf("strobe[%0d]", i), pack(act_q[i], n), pack(exp_q[i], n));
        check("done_count", done_q.size(), do_fill ? 1 : 0);
        if (do_fill && done_q.size() > 0) check("done_cycle", done_q[0] - n, exp_done - n);
        check("busy_cycles", busy_cnt, (lc == 0) ? 0 : last - n);
        check("we_exclusive", both_cnt, 0);
        plan_q.delete();
    endtask

    task automatic add_cpu(input int off, input int low, input logic [15:0] a, input logic [7:0] d, input bit mreq_n);
        cpu_t c;
        c.off = off; c.low = low; c.a = a; c.d = d; c.mreq_n = mreq_n;
        plan_q.push_back(c);
    endtask

    vec_t vecs[8];

    initial begin
        int o, ncpu;
        logic [15:0] a;
        logic [11:0] len;
        bus.wr_n = 1'b1; bus.mreq_n = 1'b1; bus.add = 16'h0000; bus.din = 8'h00;
        bus.fill_start = 1'b0; bus.fill_base = 11'h000; bus.fill_len = 12'h000;
        bus.fill_char = 8'h00; bus.fill_attr = 8'h00;

        vecs[0] = '{16'hE805, 8'h41, 1'b0, 1'b1, 1'b0, 11'h005};
        vecs[1] = '{16'hE123, 8'h1F, 1'b0, 1'b0, 1'b1, 11'h123};
        vecs[2] = '{16'hF000, 8'h55, 1'b0, 1'b0, 1'b0, 11'h000};
        vecs[3] = '{16'hE805, 8'h66, 1'b1, 1'b0, 1'b0, 11'h000};
        vecs[4] = '{16'hEFFF, 8'hAA, 1'b0, 1'b1, 1'b0, 11'h7FF};
        vecs[5] = '{16'hE7FF, 8'h3C, 1'b0, 1'b0, 1'b1, 11'h7FF};
        vecs[6] = '{16'hE800, 8'h01, 1'b0, 1'b1, 1'b0, 11'h000};
        vecs[7] = '{16'hDFFF, 8'h99, 1'b0, 1'b0, 1'b0, 11'h000};

        // Reset held with wr_n toggling.
        bus.mreq_n = 1'b0; bus.add = 16'hE805;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.wr_n = ~bus.wr_n;
        end
        @(negedge clk);
        check("rst_vr_we", bus.vr_we, 1'b0);
        check("rst_ar_we", bus.ar_we, 1'b0);
        check("rst_wadd", bus.wadd, 11'h000);
        check("rst_wdata", bus.wdata, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        bus.wr_n = 1'b1; bus.mreq_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        check("idle_strobes", act_q.size(), 0);
        check("idle_done", done_q.size(), 0);

        // CPU decode table.
        for (int v = 0; v < 8; v++) begin
            add_cpu(0, 6, vecs[v].a, vecs[v].d, vecs[v].mreq_n);
            run(1'b0, 11'h000, 12'd0, 8'h00, 8'h00, 1'b0);
            check($sformatf("vec%0d_count", v), act_q.size(), (vecs[v].vr | vecs[v].ar) ? 1 : 0);
            if (act_q.size() > 0 && (vecs[v].vr | vecs[v].ar)) begin
                check($sformatf("vec%0d_lat", v), act_q[0].cyc - last_n, 2);
                check($sformatf("vec%0d_vr", v), act_q[0].vr, vecs[v].vr);
                check($sformatf("vec%0d_ar", v), act_q[0].ar, vecs[v].ar);
                check($sformatf("vec%0d_wadd", v), act_q[0].a, vecs[v].wa);
                check($sformatf("vec%0d_wdata", v), act_q[0].d, vecs[v].d);
            end
        end

        // Basic fill.
        run(1'b1, 11'h010, 12'd3, 8'h20, 8'h07, 1'b0);
        check("fill_busy7", busy_cnt, 7);
        if (done_q.size() > 0) check("fill_done_at", done_q[0] - last_n, 8);
        if (act_q.size() == 6) check("fill_last_addr", act_q[5].a, 11'h012);

        // Wrap, clamp, zero length.
        run(1'b1, 11'h7FE, 12'd3, 8'h31, 8'h0E, 1'b0);
        if (act_q.size() == 6) check("wrap_addr", act_q[4].a, 11'h000);
        run(1'b1, 11'h123, 12'hFFF, 8'h00, 8'h70, 1'b0);
        check("clamp_4096", act_q.size(), 4096);
        run(1'b1, 11'h055, 12'd0, 8'h11, 8'h22, 1'b0);
        check("len0_strobes", act_q.size(), 0);

        // Collision with the second vr_we of the fill.
        add_cpu(2, 3, 16'hE805, 8'h41, 1'b0);
        run(1'b1, 11'h010, 12'd3, 8'h20, 8'h07, 1'b0);
        check("coll_strobes", act_q.size(), 7);
        if (done_q.size() > 0) check("coll_done_at", done_q[0] - last_n, 9);

        // Ignored out-of-range CPU event must not stall the fill.
        add_cpu(2, 3, 16'h1234, 8'h41, 1'b0);
        run(1'b1, 11'h200, 12'd3, 8'h20, 8'h07, 1'b0);

        // fill_start while busy is ignored.
        run(1'b1, 11'h300, 12'd5, 8'hA5, 8'h5A, 1'b1);

        // Reset mid-fill abandons it.
        clear_mon();
        @(negedge clk);
        bus.fill_start = 1'b1; bus.fill_base = 11'h100; bus.fill_len = 12'd20;
        @(negedge clk);
        bus.fill_start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        act_q.delete(); done_q.delete(); busy_cnt = 0; both_cnt = 0;
        check("abort_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_strobes", act_q.size(), 0);
        check("abort_done", done_q.size(), 0);
        check("abort_busy_cnt", busy_cnt, 0);
        run(1'b1, 11'h400, 12'd4, 8'h61, 8'h17, 1'b0);

        // Randomised fills with interleaved CPU traffic.
        for (int s = 0; s < 25; s++) begin
            ncpu = $urandom_range(0, 3);
            o = $urandom_range(0, 4);
            for (int j = 0; j < ncpu; j++) begin
                case ($urandom_range(0, 2))
                    0: a = 16'hE800 | 16'($urandom_range(0, 2047));
                    1: a = 16'hE000 | 16'($urandom_range(0, 2047));
                    default: a = 16'($urandom_range(0, 65535));
                endcase
                add_cpu(o, 3, a, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
                o += $urandom_range(6, 9);
            end
            len = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 10));
            run(1'b1, 11'($urandom_range(0, 2047)), len, 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), (len >= 12'd2) && ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
